// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO in front of it.
// Words come in over a valid/ready handshake and are buffered. Each word is
// then sent as one frame: start bit, DATA_W data bits LSB first, an optional
// parity bit, and STOP_BITS stop bits. Every bit lasts CLKS_PER_BIT clocks.
module uart_tx_fifo #(
  parameter int    DATA_W       = 8,
  parameter string PARITY       = "ODD",
  parameter int    STOP_BITS    = 1,
  parameter int    CLKS_PER_BIT = 16,
  parameter int    FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tx_valid,
  input  logic [DATA_W-1:0]             tx_data,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W);
  localparam bit HAS_PAR = (PARITY != "NONE");
  localparam bit ODD_PAR = (PARITY == "ODD");

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic [DATA_W-1:0] head;
  logic              push;
  logic              pop;
  logic              empty;
  logic              full;

  logic [2:0]        state;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bit_idx;
  logic [DATA_W-1:0] shreg;
  logic              par_q;
  logic              bit_end;
  logic              stop_end;

  // tx_ready comes straight from the occupancy register, so it never
  // depends on tx_valid in the same cycle.
  assign empty      = (level == '0);
  assign full       = (level == LW'(FIFO_DEPTH));
  assign tx_ready   = !full;
  assign push       = tx_valid && tx_ready;
  assign head       = mem[rd_ptr];
  assign fifo_level = level;
  assign bit_end    = (cnt == CW'(CLKS_PER_BIT - 1));
  assign stop_end   = (cnt == CW'(STOP_BITS * CLKS_PER_BIT - 1));

  // Pop the head whenever the transmitter can start a frame: from idle, or
  // on the last stop cycle so back-to-back frames have no idle gap.
  always_comb begin
    // NOTE: give every always_comb output a default first; otherwise any
    // path that skips an assignment infers a latch.
    pop = 1'b0;
    if (!empty) begin
      if (state == S_IDLE)             pop = 1'b1;
      if (state == S_STOP && stop_end) pop = 1'b1;
    end
  end

  // FIFO storage write port.
  // NOTE: the storage array has no reset. Only the pointers and the level
  // decide which entries are valid, so resetting the array would add logic
  // and do nothing useful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // FIFO pointers and occupancy count.
  // NOTE: sequential state uses non-blocking assignments. Every flop then
  // samples the values from before the edge, so the order of the statements
  // does not matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Frame sequencer. tx and busy are registered. The divider count and the
  // bit index restart whenever the state changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (pop) begin
            shreg <= head;
            par_q <= ODD_PAR ? ~^head : ^head;
            tx    <= 1'b0;
            busy  <= 1'b1;
            state <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            state   <= S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == BW'(DATA_W - 1)) begin
              if (HAS_PAR) begin
                tx    <= par_q;
                state <= S_PAR;
              end else begin
                tx    <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PAR: begin
          if (bit_end) begin
            cnt   <= '0;
            tx    <= 1'b1;
            state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (stop_end) begin
            cnt <= '0;
            if (pop) begin
              shreg <= head;
              par_q <= ODD_PAR ? ~^head : ^head;
              tx    <= 1'b0;
              state <= S_START;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo.
// Runs three instances (ODD/1 stop, EVEN/1 stop, NONE/2 stops; all with
// CLKS_PER_BIT=4 and FIFO_DEPTH=4) against a frame-level reference model.
// The model keeps a word queue and the position of the current frame, and
// reads the expected line level from a bit list built for that frame.
module tb_uart_tx_fifo;

  localparam int C  = 4;
  localparam int DP = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v [3];
  logic [7:0] dt [3];
  logic       rdy [3];
  logic       txo [3];
  logic       bsy [3];
  logic [2:0] lvl [3];

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  cmp_on  = 1'b0;

  // Reference model state.
  logic [7:0] m_mem [3][64];
  int         m_head [3];
  int         m_tail [3];
  int         m_level [3];
  bit         m_busy [3];
  int         m_pos [3];
  logic [7:0] m_cur [3];
  int         m_npush [3];

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_W(8), .PARITY("ODD"), .STOP_BITS(1), .CLKS_PER_BIT(C), .FIFO_DEPTH(DP)) dut0 (
    .clk(clk), .rst_n(rst_n), .tx_valid(v[0]), .tx_data(dt[0]),
    .tx_ready(rdy[0]), .tx(txo[0]), .busy(bsy[0]), .fifo_level(lvl[0]));
  uart_tx_fifo #(.DATA_W(8), .PARITY("EVEN"), .STOP_BITS(1), .CLKS_PER_BIT(C), .FIFO_DEPTH(DP)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_valid(v[1]), .tx_data(dt[1]),
    .tx_ready(rdy[1]), .tx(txo[1]), .busy(bsy[1]), .fifo_level(lvl[1]));
  uart_tx_fifo #(.DATA_W(8), .PARITY("NONE"), .STOP_BITS(2), .CLKS_PER_BIT(C), .FIFO_DEPTH(DP)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_valid(v[2]), .tx_data(dt[2]),
    .tx_ready(rdy[2]), .tx(txo[2]), .busy(bsy[2]), .fifo_level(lvl[2]));

  function automatic bit has_par(int d);
    return d != 2;
  endfunction

  function automatic int flen(int d);
    return (1 + 8 + (has_par(d) ? 1 : 0) + (d == 2 ? 2 : 1)) * C;
  endfunction

  // Level of bit i of the frame that carries word w.
  function automatic bit frame_bit(int d, logic [7:0] w, int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return w[i-1];
    if (has_par(d) && i == 9) return (d == 0) ? ~^w : ^w;
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model update. On each edge it decides push and pop from the values the
  // design sees before that edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) begin
        m_head[d] = 0; m_tail[d] = 0; m_level[d] = 0;
        m_busy[d] = 0; m_pos[d] = 0; m_cur[d] = '0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        bit push, pop;
        push = v[d] && (m_level[d] < DP);
        pop  = 0;
        if (!m_busy[d]) begin
          if (m_level[d] > 0) begin pop = 1; m_busy[d] = 1; m_pos[d] = 0; end
        end else if (m_pos[d] == flen(d) - 1) begin
          if (m_level[d] > 0) begin pop = 1; m_pos[d] = 0; end
          else m_busy[d] = 0;
        end else begin
          m_pos[d]++;
        end
        if (pop) begin m_cur[d] = m_mem[d][m_head[d] % 64]; m_head[d]++; end
        if (push) begin m_mem[d][m_tail[d] % 64] = dt[d]; m_tail[d]++; m_npush[d]++; end
        m_level[d] = m_level[d] + (push ? 1 : 0) - (pop ? 1 : 0);
      end
    end
  end

  // Compare every instance against the model on every falling edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int d = 0; d < 3; d++) begin
        logic exp_tx;
        exp_tx = m_busy[d] ? frame_bit(d, m_cur[d], m_pos[d] / C) : 1'b1;
        check($sformatf("d%0d tx", d), 32'(txo[d]), 32'(exp_tx));
        check($sformatf("d%0d busy", d), 32'(bsy[d]), 32'(m_busy[d]));
        check($sformatf("d%0d level", d), 32'(lvl[d]), 32'(m_level[d]));
        check($sformatf("d%0d ready", d), 32'(rdy[d]), 32'(m_level[d] < DP));
      end
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (m_level[0] == 0 && m_level[1] == 0 && m_level[2] == 0 &&
          !m_busy[0] && !m_busy[1] && !m_busy[2] && !bsy[0] && !bsy[1] && !bsy[2]) break;
    end
    for (int d = 0; d < 3; d++) begin
      check($sformatf("d%0d idle busy", d), 32'(bsy[d]), 32'd0);
      check($sformatf("d%0d idle level", d), 32'(lvl[d]), 32'd0);
    end
  endtask

  bit lit [3][11] = '{'{0,1,0,1,0,0,1,0,1,1,1},
                      '{0,1,0,1,0,0,1,0,1,0,1},
                      '{0,0,0,1,1,1,1,0,0,1,1}};

  initial begin
    logic [7:0] w [6];
    int         np;
    for (int d = 0; d < 3; d++) begin v[d] = 0; dt[d] = '0; m_npush[d] = 0; end

    // Values held during reset.
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("d%0d rst tx", d), 32'(txo[d]), 32'd1);
      check($sformatf("d%0d rst busy", d), 32'(bsy[d]), 32'd0);
      check($sformatf("d%0d rst level", d), 32'(lvl[d]), 32'd0);
      check($sformatf("d%0d rst ready", d), 32'(rdy[d]), 32'd1);
    end
    #2 rst_n = 1'b1;
    cmp_on = 1'b1;

    // Single frames with hand-derived bit patterns. The line must go low on
    // the edge after the push.
    @(negedge clk);
    v[0] = 1; dt[0] = 8'hA5; v[1] = 1; dt[1] = 8'hA5; v[2] = 1; dt[2] = 8'h3C;
    @(negedge clk);
    for (int d = 0; d < 3; d++) v[d] = 0;
    for (int k = 0; k < 44; k++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        check($sformatf("d%0d lit tx c%0d", d, k), 32'(txo[d]), 32'(lit[d][k / C]));
        check($sformatf("d%0d lit busy c%0d", d, k), 32'(bsy[d]), 32'd1);
      end
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("d%0d lit end busy", d), 32'(bsy[d]), 32'd0);
      check($sformatf("d%0d lit end tx", d), 32'(txo[d]), 32'd1);
    end

    // Hold tx_valid high for six words. The FIFO must fill after five edges.
    wait_idle();
    for (int i = 0; i < 6; i++) w[i] = 8'($urandom);
    np = m_npush[0];
    for (int k = 0; k < 2000 && (m_npush[0] - np) < 6; k++) begin
      @(negedge clk);
      if (k == 5) begin
        check("fill level", 32'(lvl[0]), 32'd4);
        check("fill ready", 32'(rdy[0]), 32'd0);
      end
      v[0] = 1; dt[0] = w[m_npush[0] - np];
    end
    @(negedge clk);
    v[0] = 0;
    check("fill pushes", 32'(m_npush[0] - np), 32'd6);
    wait_idle();

    // Reset in the middle of the data bits while two words are still queued.
    @(negedge clk);
    v[0] = 1; dt[0] = 8'h11;
    @(negedge clk); dt[0] = 8'h22;
    @(negedge clk); dt[0] = 8'h33;
    @(negedge clk); v[0] = 0;
    repeat (8) @(negedge clk);
    check("pre-reset level", 32'(lvl[0]), 32'd2);
    check("pre-reset busy", 32'(bsy[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst tx", 32'(txo[0]), 32'd1);
    check("async rst busy", 32'(bsy[0]), 32'd0);
    check("async rst level", 32'(lvl[0]), 32'd0);
    check("async rst ready", 32'(rdy[0]), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("post-reset idle tx", 32'(txo[0]), 32'd1);
      check("post-reset idle busy", 32'(bsy[0]), 32'd0);
    end

    // Random traffic at several push rates.
    for (int ph = 0; ph < 4; ph++) begin
      int prob;
      prob = (ph == 0) ? 10 : (ph == 1) ? 40 : (ph == 2) ? 70 : 95;
      for (int k = 0; k < 750; k++) begin
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
          v[d]  = ($urandom_range(0, 99) < prob);
          dt[d] = 8'($urandom);
        end
      end
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) v[d] = 0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
